// File: rtl/neuai_pwm_capture_pkg.sv
// Shared definitions for the PWM capture block.
//   - FSM state encoding
//   - default prescaler divide and counter width
//   - tick period shared with the clk_1us generator
package neuai_pwm_capture_pkg;

  localparam int CLK_DIV_DEF  = 50;  // 50 MHz system clock -> 1 us tick
  localparam int CNT_W_DEF    = 10;  // 0..1023 ticks, 1023 = timeout
  localparam int TICK_US_CLKS = 50;  // system clocks per 1 us, same as clk_1us gen

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/neuai_pwm_capture_sync.sv
// neuai_sync_edge: 2-flop synchronizer plus history flop with rise/fall detect.
// W independent lanes, so the same block serves key inputs as well.
//   w_clk   system clock
//   w_rst   async active-low reset
//   w_in    asynchronous inputs
//   w_level synchronized level (s2)
//   w_rise  s2 & ~s3
//   w_fall  ~s2 & s3
module neuai_sync_edge #(
  parameter int W = 1
) (
  input  logic         w_clk,
  input  logic         w_rst,
  input  logic [W-1:0] w_in,
  output logic [W-1:0] w_level,
  output logic [W-1:0] w_rise,
  output logic [W-1:0] w_fall
);

  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= w_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign w_level = s2;
  assign w_rise  = s2 & ~s3;
  assign w_fall  = ~s2 & s3;

endmodule

// File: rtl/neuai_pwm_capture.sv
// PWM capture: measures high time and period (rise to rise) of w_pwm_in in
// prescaled ticks, with a timeout when no rising edge arrives.
//   w_clk        system clock
//   w_rst        async active-low reset
//   w_pwm_in     asynchronous PWM input
//   w_high_cnt   last completed high time (ticks)
//   w_period_cnt last completed period (ticks)
//   w_valid      1-cycle pulse after w_high_cnt/w_period_cnt update
//   w_stuck      no rising edge within 2^CNT_W-1 ticks
//   w_level      synchronized input level
module neuai_pwm_capture
  import neuai_pwm_capture_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             w_pwm_in,
  output logic [CNT_W-1:0] w_high_cnt,
  output logic [CNT_W-1:0] w_period_cnt,
  output logic             w_valid,
  output logic             w_stuck,
  output logic             w_level
);

  localparam int               PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic             rise, fall;
  logic [PW-1:0]    presc;
  logic             tick;
  logic             tmo;
  cap_state_e       state;
  logic [CNT_W-1:0] hi_cnt, per_cnt;
  logic             lat_evt;  // delays w_valid one cycle behind the latch

  neuai_sync_edge #(.W(1)) u_sync (
    .w_clk  (w_clk),
    .w_rst  (w_rst),
    .w_in   (w_pwm_in),
    .w_level(w_level),
    .w_rise (rise),
    .w_fall (fall)
  );

  // Prescaler re-phases on every rise so tick boundaries align to the period.
  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst)              presc <= '0;
    else if (rise || tick)   presc <= '0;
    else                     presc <= presc + 1'b1;
  end

  assign tick = (presc == PRESC_LAST);
  // This tick would push per_cnt to the all-ones value: declare timeout.
  assign tmo  = tick && (per_cnt == CNT_MAX - 1'b1);

  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      state        <= IDLE;
      hi_cnt       <= '0;
      per_cnt      <= '0;
      w_high_cnt   <= '0;
      w_period_cnt <= '0;
      lat_evt      <= 1'b0;
      w_valid      <= 1'b0;
      w_stuck      <= 1'b0;
    end else begin
      lat_evt <= 1'b0;
      w_valid <= lat_evt;
      case (state)
        IDLE: begin
          hi_cnt  <= '0;
          per_cnt <= '0;
          if (rise) state <= HIGH;
        end
        HIGH: begin
          if (rise) begin
            // Unreachable in normal operation; restart without latching.
            hi_cnt  <= '0;
            per_cnt <= '0;
          end else if (tmo) begin
            w_stuck <= 1'b1;
            state   <= IDLE;
          end else begin
            // A tick on the falling cycle still counts as high time.
            if (tick) begin
              hi_cnt  <= hi_cnt + 1'b1;
              per_cnt <= per_cnt + 1'b1;
            end
            if (fall) state <= LOW;
          end
        end
        LOW: begin
          if (rise) begin
            // Tick coinciding with the rise is dropped from the latched period.
            w_high_cnt   <= hi_cnt;
            w_period_cnt <= per_cnt;
            lat_evt      <= 1'b1;
            w_stuck      <= 1'b0;
            hi_cnt       <= '0;
            per_cnt      <= '0;
            state        <= HIGH;
          end else if (tmo) begin
            w_stuck <= 1'b1;
            state   <= IDLE;
          end else if (tick) begin
            per_cnt <= per_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuai_pwm_capture.sv
module tb_neuai_pwm_capture;

  localparam int DIV  = 5;
  localparam int CW   = 8;
  localparam int TMO  = (1 << CW) * DIV + 10;  // clocks comfortably past timeout

  logic          w_clk = 1'b0;
  logic          w_rst = 1'b0;
  logic          w_pwm_in = 1'b0;
  logic [CW-1:0] w_high_cnt, w_period_cnt;
  logic          w_valid, w_stuck, w_level;

  neuai_pwm_capture #(.CLK_DIV(DIV), .CNT_W(CW)) dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .w_pwm_in    (w_pwm_in),
    .w_high_cnt  (w_high_cnt),
    .w_period_cnt(w_period_cnt),
    .w_valid     (w_valid),
    .w_stuck     (w_stuck),
    .w_level     (w_level)
  );

  always #5 w_clk = ~w_clk;

  int cyc = 0;
  always @(posedge w_clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Reference model: waveform lengths in clocks, converted to ticks.
  int exp_hi[$], exp_per[$];
  int obs_hi[$], obs_per[$], obs_lat[$];
  bit armed = 0;
  int last_rise = 0, hi_len = 0, last_hi = 0, last_per = 0;

  always @(negedge w_clk) begin
    if (w_valid) begin
      obs_hi.push_back(int'(w_high_cnt));
      obs_per.push_back(int'(w_period_cnt));
      obs_lat.push_back(cyc - last_rise);
    end
  end

  task automatic chk_n(input string tag, input int obs, input int exp, input int tol);
    n_chk++;
    assert (obs >= exp - tol && obs <= exp + tol) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d (+-%0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // Hold w_pwm_in at v for n clocks, updating the model on edges.
  task automatic drive(input logic v, input int n);
    @(posedge w_clk); #1;
    if (v && !w_pwm_in) begin
      if (armed) begin
        last_hi  = hi_len / DIV;
        last_per = (cyc - last_rise) / DIV;
        exp_hi.push_back(last_hi);
        exp_per.push_back(last_per);
      end
      armed     = 1;
      last_rise = cyc;
    end else if (!v && w_pwm_in) begin
      hi_len = cyc - last_rise;
    end
    w_pwm_in = v;
    repeat (n - 1) @(posedge w_clk);
  endtask

  task automatic rand_periods(input int k);
    for (int i = 0; i < k; i++) begin
      int p, h;
      p = $urandom_range(120, 20);
      h = $urandom_range(p - 1, 1);
      drive(1'b1, h * DIV);
      drive(1'b0, (p - h) * DIV);
    end
  endtask

  task automatic check_meas(input string tag);
    repeat (8) @(posedge w_clk);
    chk_n({tag, " count"}, obs_hi.size(), exp_hi.size(), 0);
    while (exp_hi.size() > 0 && obs_hi.size() > 0) begin
      chk_n({tag, " high"},    obs_hi.pop_front(),  exp_hi.pop_front(),  1);
      chk_n({tag, " period"},  obs_per.pop_front(), exp_per.pop_front(), 1);
      chk_n({tag, " latency"}, obs_lat.pop_front(), 4, 0);
    end
    exp_hi.delete(); exp_per.delete();
    obs_hi.delete(); obs_per.delete(); obs_lat.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge w_clk);
    @(negedge w_clk);
    chk_n("rst high", int'(w_high_cnt), 0, 0);
    chk_n("rst period", int'(w_period_cnt), 0, 0);
    chk_b("rst valid", w_valid, 1'b0);
    chk_b("rst stuck", w_stuck, 1'b0);
    chk_b("rst level", w_level, 1'b0);
    w_rst = 1'b1;

    // Fixed 30% duty then random waveforms; first rise only arms
    drive(1'b1, 30 * DIV);
    drive(1'b0, 70 * DIV);
    rand_periods(8);
    drive(1'b1, 20);
    check_meas("rand");
    chk_b("lock stuck", w_stuck, 1'b0);

    // Constant high: timeout, last values held, no valid
    repeat (TMO) @(posedge w_clk);
    @(negedge w_clk);
    chk_b("hi-tmo stuck", w_stuck, 1'b1);
    chk_b("hi-tmo level", w_level, 1'b1);
    chk_n("hi-tmo hold high", int'(w_high_cnt), last_hi, 1);
    chk_n("hi-tmo hold period", int'(w_period_cnt), last_per, 1);
    chk_n("hi-tmo no valid", obs_hi.size(), 0, 0);
    armed = 0;

    // Restart: first rise arms only, stuck clears with first valid
    drive(1'b0, 30);
    drive(1'b1, 40 * DIV);
    @(negedge w_clk);
    chk_b("rearm stuck", w_stuck, 1'b1);
    drive(1'b0, 50 * DIV);
    rand_periods(3);
    drive(1'b1, 20);
    check_meas("restart");
    chk_b("restart stuck", w_stuck, 1'b0);

    // Sub-tick glitch inside LOW restarts the period with zero high time
    drive(1'b0, 40);
    drive(1'b1, 1);
    drive(1'b0, 60);
    drive(1'b1, 30);
    drive(1'b0, 50);
    drive(1'b1, 10);
    check_meas("glitch");

    // Constant low: timeout with level 0
    drive(1'b0, 20);
    repeat (TMO) @(posedge w_clk);
    @(negedge w_clk);
    chk_b("lo-tmo stuck", w_stuck, 1'b1);
    chk_b("lo-tmo level", w_level, 1'b0);
    chk_n("lo-tmo no valid", obs_hi.size(), 0, 0);
    armed = 0;

    // Reset mid-HIGH: outputs clear asynchronously
    drive(1'b1, 30);
    @(negedge w_clk);
    #2 w_rst = 1'b0;
    #1;
    chk_n("mid-rst high", int'(w_high_cnt), 0, 0);
    chk_n("mid-rst period", int'(w_period_cnt), 0, 0);
    chk_b("mid-rst valid", w_valid, 1'b0);
    chk_b("mid-rst stuck", w_stuck, 1'b0);
    chk_b("mid-rst level", w_level, 1'b0);
    w_pwm_in = 1'b0;
    armed = 0;
    repeat (3) @(posedge w_clk);
    @(negedge w_clk);
    w_rst = 1'b1;
    rand_periods(3);
    drive(1'b1, 20);
    check_meas("post-rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
